fifo_multi_drain: RTL and testbench



---
 rtl/fifo_multi_drain.sv | 129 ++++++++++++
 tb/tb_fifo_multi_drain.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_multi_drain.sv
// Round-robin read-side drain for the fifo_multi subbuffer array: picks a non-empty
// subbuffer, pops up to b words from it, and presents each word with its channel tag.
module fifo_multi_drain #(
   parameter int n = 8,
   parameter int o = 8,
   parameter int w = 7,
   parameter int b = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [w*o-1:0]       status,
   output logic [$clog2(o)-1:0] addr_o,
   output logic                 pop,
   input  logic [n-1:0]         data_i,
   output logic [n-1:0]         data_o,
   output logic [$clog2(o)-1:0] ch_o,
   output logic                 valid,
   input  logic                 ready
);

   localparam int aw = $clog2(o);
   localparam int bw = $clog2(b + 1);

   typedef enum logic [1:0] {SCAN, POP, CAPT, HOLD} state_t;

   state_t        state;
   state_t        next_state;
   logic [aw-1:0] ptr;
   logic [aw-1:0] pick;
   logic [bw-1:0] burst;
   logic [o-1:0]  nonempty;
   logic          found;
   logic          handshake;
   logic          more;

   // Only a zero fill count means empty; no other status bits are interpreted.
   always_comb begin
      nonempty = {o{1'b0}};
      for (int k = 0; k < o; k++) begin
         nonempty[k] = (status[w*k +: w] != {w{1'b0}});
      end
   end

   // Search ptr+1 .. ptr+o (wrapping), so the last granted index gets lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int i = 1; i <= o; i++) begin
         if (!found && nonempty[ptr + aw'(i)]) begin
            found = 1'b1;
            pick  = ptr + aw'(i);
         end
      end
   end

   // Status seen during the handshake already reflects the completed pop.
   always_comb begin
      handshake = (state == HOLD) && valid && ready;
      more      = (burst < bw'(b)) && nonempty[addr_o];
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         SCAN: begin
            if (found) begin
               next_state = POP;
            end else begin
               next_state = SCAN;
            end
         end
         POP:  next_state = CAPT;
         CAPT: next_state = HOLD;
         HOLD: begin
            if (!handshake) begin
               next_state = HOLD;
            end else if (more) begin
               next_state = POP;
            end else begin
               next_state = SCAN;
            end
         end
         default: next_state = SCAN;
      endcase
   end

   // State register and registered datapath/outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= SCAN;
         ptr    <= aw'(o - 1);
         burst  <= {bw{1'b0}};
         addr_o <= {aw{1'b0}};
         pop    <= 1'b0;
         valid  <= 1'b0;
         data_o <= {n{1'b0}};
         ch_o   <= {aw{1'b0}};
      end else begin
         state <= next_state;
         pop   <= (next_state == POP);
         case (state)
            SCAN: begin
               if (found) begin
                  addr_o <= pick;
                  burst  <= bw'(1);
               end
            end
            CAPT: begin
               data_o <= data_i;
               ch_o   <= addr_o;
               valid  <= 1'b1;
            end
            HOLD: begin
               if (handshake) begin
                  valid <= 1'b0;
                  if (more) begin
                     burst <= burst + bw'(1);
                  end else begin
                     ptr <= addr_o;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_multi_drain.sv
// Bench for fifo_multi_drain (o=4, b=2): a queue model of fifo_multi feeds the DUT and a
// transaction-level round-robin model predicts the grant order and delivered words.
module tb_fifo_multi_drain;

   localparam int n  = 8;
   localparam int o  = 4;
   localparam int w  = 7;
   localparam int b  = 2;
   localparam int aw = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ready = 1'b0;
   logic [w*o-1:0] status;
   logic [aw-1:0]  addr_o;
   logic           pop;
   logic [n-1:0]   data_i = '0;
   logic [n-1:0]   data_o;
   logic [aw-1:0]  ch_o;
   logic           valid;

   int checks = 0;
   int passed = 0;

   // Upstream subbuffer model: mem/wr owned by the stimulus, rd by the pop monitor.
   logic [n-1:0]  mem [o][64];
   int            wr [o];
   int            rd [o];
   int            npop = 0;
   int            nacc = 0;
   int            bad_pop = 0;
   logic [aw-1:0] pop_log [1024];
   logic [n-1:0]  acc_d [1024];
   logic [aw-1:0] acc_c [1024];

   int            exp_c [$];
   logic [n-1:0]  exp_d [$];

   fifo_multi_drain #(.n(n), .o(o), .w(w), .b(b)) dut (
      .clk(clk), .rst(rst), .status(status), .addr_o(addr_o), .pop(pop),
      .data_i(data_i), .data_o(data_o), .ch_o(ch_o), .valid(valid), .ready(ready)
   );

   always #5 clk = ~clk;

   for (genvar k = 0; k < o; k++) begin : g_status
      assign status[w*k +: w] = 7'(wr[k] - rd[k]);
   end

   always @(posedge clk) begin
      if (pop) begin
         if (wr[addr_o] == rd[addr_o]) begin
            bad_pop <= bad_pop + 1;
            data_i  <= 8'hEE;
         end else begin
            data_i      <= mem[addr_o][rd[addr_o] % 64];
            rd[addr_o]  <= rd[addr_o] + 1;
         end
         pop_log[npop % 1024] <= addr_o;
         npop <= npop + 1;
      end else begin
         data_i <= 8'($urandom);
      end
      if (valid && ready) begin
         acc_d[nacc % 1024] <= data_o;
         acc_c[nacc % 1024] <= ch_o;
         nacc <= nacc + 1;
      end
   end

   task automatic push(input int c, input logic [n-1:0] d);
      mem[c][wr[c] % 64] = d;
      wr[c] = wr[c] + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (status == '0 && !valid && !pop) quiet++;
         else quiet = 0;
         if (quiet >= 4) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Round-robin over preloaded fill counts: up to b words per grant, grantee goes last.
   task automatic model_seq(input int cnt [o], input int st [o]);
      int p = o - 1;
      int left [o];
      int used [o];
      exp_c.delete();
      exp_d.delete();
      for (int c = 0; c < o; c++) begin
         left[c] = cnt[c];
         used[c] = 0;
      end
      forever begin
         int g = -1;
         for (int i = 1; i <= o; i++) begin
            if (g < 0 && left[(p + i) % o] > 0) g = (p + i) % o;
         end
         if (g < 0) break;
         for (int k = 0; k < b && left[g] > 0; k++) begin
            exp_c.push_back(g);
            exp_d.push_back(mem[g][(st[g] + used[g]) % 64]);
            used[g]++;
            left[g]--;
         end
         p = g;
      end
   endtask

   task automatic test_reset();
      int s;
      rst = 1'b1;
      ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({pop, valid, addr_o, ch_o, data_o} !== '0) begin
            $display("FAIL reset_outputs: pop=%b valid=%b addr_o=%0d ch_o=%0d data_o=%h, required all 0",
                     pop, valid, addr_o, ch_o, data_o);
         end else passed++;
      end
      rst = 1'b0;
      s = npop;
      repeat (10) @(negedge clk);
      checks++;
      if (npop !== s || valid !== 1'b0) begin
         $display("FAIL reset_idle: pops=%0d valid=%b, required 0 pops valid=0", npop - s, valid);
      end else passed++;
   endtask

   task automatic test_single();
      int s = npop;
      int a = nacc;
      bit ok;
      logic [n-1:0] want [3];
      want[0] = 8'hA1;
      want[1] = 8'hA2;
      want[2] = 8'hA3;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) push(2, want[i]);
      wait_idle(100, ok);
      checks++;
      if (!ok) $display("FAIL single_idle: did not return to idle within bound");
      else passed++;
      checks++;
      if (npop - s !== 3) $display("FAIL single_pops: got %0d pops, required 3", npop - s);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (acc_d[a + i] !== want[i] || acc_c[a + i] !== 2'd2 || pop_log[s + i] !== 2'd2) begin
            $display("FAIL single_word%0d: data=%h ch=%0d pop_idx=%0d, required data=%h ch=2 pop_idx=2",
                     i, acc_d[a + i], acc_c[a + i], pop_log[s + i], want[i]);
         end else passed++;
      end
   endtask

   task automatic test_rr_burst();
      int s;
      int lat = 0;
      bit ok;
      @(negedge clk);
      rst = 1'b1;
      ready = 1'b1;
      for (int c = 0; c < o; c++) begin
         for (int k = 0; k < 5; k++) push(c, 8'($urandom));
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s = npop;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (valid && lat == 0) lat = i;
      end
      checks++;
      if (lat !== 3) $display("FAIL rr_latency: first valid after %0d cycles, required 3", lat);
      else passed++;
      for (int i = 0; i < 100 && npop < s + 10; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (npop < s + 10 || pop_log[s + i] !== 2'((i / 2) % o)) begin
            $display("FAIL rr_order%0d: pop index %0d (pops seen %0d), required %0d",
                     i, pop_log[s + i], npop - s, (i / 2) % o);
         end else passed++;
      end
      wait_idle(300, ok);
      checks++;
      if (!ok) $display("FAIL rr_drain: did not drain within bound");
      else passed++;
   endtask

   task automatic test_backpressure();
      int s = npop;
      int a;
      int bad = 0;
      bit got = 1'b0;
      bit ok;
      ready = 1'b0;
      push(1, 8'h5C);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = valid;
      end
      checks++;
      if (!got) $display("FAIL bp_valid: valid not seen within 20 cycles");
      else passed++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid !== 1'b1 || data_o !== 8'h5C || ch_o !== 2'd1) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
      else passed++;
      checks++;
      if (npop - s !== 1) $display("FAIL bp_pops: got %0d pops, required 1", npop - s);
      else passed++;
      a = nacc;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0 || nacc !== a + 1 || acc_d[a] !== 8'h5C) begin
         $display("FAIL bp_handshake: valid=%b accepted=%0d data=%h, required valid=0 accepted=1 data=5c",
                  valid, nacc - a, acc_d[a]);
      end else passed++;
      wait_idle(50, ok);
   endtask

   task automatic test_wrap();
      int s;
      bit ok;
      do_reset();
      ready = 1'b1;
      push(3, 8'h33);
      wait_idle(50, ok);
      s = npop;
      push(1, 8'h11);
      wait_idle(50, ok);
      checks++;
      if (npop - s !== 1 || pop_log[s] !== 2'd1) begin
         $display("FAIL wrap_to_1: pops=%0d idx=%0d, required 1 pop idx=1", npop - s, pop_log[s]);
      end else passed++;
      s = npop;
      push(0, 8'h00);
      push(2, 8'h22);
      wait_idle(50, ok);
      checks++;
      if (npop - s !== 2 || pop_log[s] !== 2'd2 || pop_log[s + 1] !== 2'd0) begin
         $display("FAIL wrap_after_1: pops=%0d order=%0d,%0d, required 2,0",
                  npop - s, pop_log[s], pop_log[s + 1]);
      end else passed++;
   endtask

   task automatic test_rst_mid();
      int s;
      bit got = 1'b0;
      bit ok;
      do_reset();
      for (int k = 0; k < 4; k++) push(2, 8'(8'h60 + k));
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = valid;
      end
      rst = 1'b1;
      push(0, 8'h0F);
      @(negedge clk);
      checks++;
      if (!got || valid !== 1'b0 || pop !== 1'b0) begin
         $display("FAIL rst_mid_clear: held_valid=%b valid=%b pop=%b, required 1,0,0", got, valid, pop);
      end else passed++;
      rst = 1'b0;
      ready = 1'b1;
      s = npop;
      for (int i = 0; i < 20 && npop == s; i++) @(negedge clk);
      checks++;
      if (npop == s || pop_log[s] !== 2'd0) begin
         $display("FAIL rst_mid_first: pops=%0d idx=%0d, required first idx=0", npop - s, pop_log[s]);
      end else passed++;
      wait_idle(100, ok);
      checks++;
      if (!ok) $display("FAIL rst_mid_drain: did not drain within bound");
      else passed++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         int cnt [o];
         int st [o];
         int total = 0;
         int s;
         int a;
         bit ok;
         @(negedge clk);
         rst = 1'b1;
         ready = 1'b0;
         for (int c = 0; c < o; c++) begin
            cnt[c] = $urandom_range(0, 7);
            st[c] = wr[c];
            total += cnt[c];
            for (int k = 0; k < cnt[c]; k++) push(c, 8'($urandom));
         end
         if (total == 0) begin
            cnt[it % o] = 1;
            total = 1;
            push(it % o, 8'($urandom));
         end
         model_seq(cnt, st);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         s = npop;
         a = nacc;
         for (int i = 0; i < 2000 && nacc < a + total; i++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 9) < 6);
         end
         ready = 1'b1;
         wait_idle(100, ok);
         checks++;
         if (nacc - a !== total || !ok) begin
            $display("FAIL rand%0d_count: accepted %0d idle=%b, required %0d idle=1", it, nacc - a, ok, total);
         end else passed++;
         for (int i = 0; i < total; i++) begin
            checks++;
            if (acc_c[a + i] !== 2'(exp_c[i]) || acc_d[a + i] !== exp_d[i] || pop_log[s + i] !== 2'(exp_c[i])) begin
               $display("FAIL rand%0d_word%0d: ch=%0d data=%h pop_idx=%0d, required ch=%0d data=%h",
                        it, i, acc_c[a + i], acc_d[a + i], pop_log[s + i], exp_c[i], exp_d[i]);
            end else passed++;
         end
      end
      checks++;
      if (bad_pop !== 0) $display("FAIL empty_pop: %0d pops of empty subbuffers, required 0", bad_pop);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_burst();
      test_backpressure();
      test_wrap();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
